uart_rx_oversample: RTL and testbench

Oversampling UART receive path: recovers 8N1 frames from an asynchronous serial line by sampling each bit OVERSAMPLE times and majority-voting the three mid-bit samples. Received bytes go out on a ready/valid interface; framing errors and overruns are flagged. It is the noise-tolerant receive-side counterpart to the existing UART transmit path and drops into the UART top-level wherever a byte-stream consumer sits behind the serial pin.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx_oversample.sv | 147 ++++++++++++++
 tb/tb_uart_rx_oversample.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and the 3-sample majority vote
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DATA_BITS          = 8;

  // Vote samples sit at these offsets around the mid-bit sample OVERSAMPLE/2.
  localparam int VOTE_FIRST_OFS = -1;
  localparam int VOTE_MID_OFS   = 0;
  localparam int VOTE_LAST_OFS  = 1;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divide-by-DIV counter with synchronous clear and tick
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// rtl/uart_rx_oversample.sv - oversampling 8N1 UART receiver with majority vote and ready/valid output
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int DIV = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int M   = OVERSAMPLE / 2;

  localparam logic [SW-1:0] S_VOTE_A = SW'(M + VOTE_FIRST_OFS);
  localparam logic [SW-1:0] S_VOTE_B = SW'(M + VOTE_MID_OFS);
  localparam logic [SW-1:0] S_VOTE_C = SW'(M + VOTE_LAST_OFS);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 sync1;
  logic                 rx;
  rx_state_t            state;
  rx_state_t            next_state;
  logic [SW-1:0]        sample_idx;
  logic [BW-1:0]        bit_cnt;
  logic                 vote_a;
  logic                 vote_b;
  logic                 bit_vote;
  logic [DATA_BITS-1:0] shift;

  logic tick;
  logic start_det;
  logic at_vote_end;
  logic at_last;
  logic bit_val;
  logic deliver;
  logic frame_bad;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (start_det),
    .tick  (tick)
  );

  assign at_vote_end = (sample_idx == S_VOTE_C);
  assign at_last     = (sample_idx == S_LAST);
  // Third vote sample is taken live so the decision lands on the M+1 tick itself.
  assign bit_val     = majority3(vote_a, vote_b, rx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (!rx) next_state = START;
      START: begin
        if (tick && at_vote_end && bit_val) begin
          next_state = IDLE;
        end else if (tick && at_last) begin
          next_state = DATA;
        end
      end
      DATA:  if (tick && at_last && bit_cnt == LAST_BIT) next_state = STOP;
      STOP:  if (tick && at_vote_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    start_det = (state == IDLE) && !rx;
    deliver   = 1'b0;
    frame_bad = 1'b0;
    if (state == STOP && tick && at_vote_end) begin
      deliver   = bit_val;
      frame_bad = !bit_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1          <= 1'b1;
      rx             <= 1'b1;
      sample_idx     <= '0;
      bit_cnt        <= '0;
      vote_a         <= 1'b0;
      vote_b         <= 1'b0;
      bit_vote       <= 1'b0;
      shift          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      framing_error  <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      sync1         <= serial_in;
      rx            <= sync1;
      framing_error <= frame_bad;
      overrun       <= 1'b0;

      if (start_det) begin
        sample_idx <= '0;
        vote_a     <= 1'b0;
        vote_b     <= 1'b0;
        bit_vote   <= 1'b0;
      end else if (tick && state != IDLE) begin
        sample_idx <= at_last ? '0 : sample_idx + 1'b1;
        if (sample_idx == S_VOTE_A) vote_a <= rx;
        if (sample_idx == S_VOTE_B) vote_b <= rx;
        if (at_vote_end) bit_vote <= bit_val;
        if (at_last && state == START) bit_cnt <= '0;
        if (at_last && state == DATA) begin
          shift   <= {bit_vote, shift[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // A byte arriving while the register is full is dropped unless the consumer frees it this cycle.
      if (deliver) begin
        if (!data_out_valid || data_out_ready) begin
          data_out       <= shift;
          data_out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb/tb_uart_rx_oversample.sv - directed frames checked against an event-level receiver model
module tb_uart_rx_oversample;

  localparam int CYC_PER_BIT = 160;
  localparam int FRAME_POS   = 10 * CYC_PER_BIT;
  // First start-bit sample edge F: rx low at F+1, start detect, result visible after edge F+1+1541.
  localparam int DELIVER_OFS = 1542;

  typedef struct {
    int         cyc;
    bit         is_frame_err;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic       data_out_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       framing_error;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  ev_t evq[$];

  int         valid_cnt = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         last_rise = -1;
  logic [7:0] last_rise_data = 8'h00;

  uart_rx_oversample #(
    .CLOCK_FREQ (1_600_000),
    .BAUD_RATE  (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin : cmp
    logic       m_valid;
    logic [7:0] m_data;
    logic       e_fe;
    logic       e_ov;
    logic       r;
    logic       rs;
    logic       delivered;
    logic       prev_valid;
    ev_t        ev;
    m_valid = 1'b0;
    m_data = 8'h00;
    prev_valid = 1'b0;
    forever begin
      @(posedge clk);
      r = data_out_ready;
      rs = reset;
      #1;
      e_fe = 1'b0;
      e_ov = 1'b0;
      delivered = 1'b0;
      if (rs) begin
        m_valid = 1'b0;
        m_data = 8'h00;
        evq.delete();
      end else begin
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
          ev = evq.pop_front();
          if (ev.is_frame_err) begin
            e_fe = 1'b1;
          end else if (m_valid && !r) begin
            e_ov = 1'b1;
            delivered = 1'b1;
          end else begin
            m_data = ev.data;
            m_valid = 1'b1;
            delivered = 1'b1;
          end
        end
        if (!delivered && m_valid && r) m_valid = 1'b0;
      end
      chk("valid", {31'd0, data_out_valid}, {31'd0, m_valid});
      chk("data", {24'd0, data_out}, {24'd0, m_data});
      chk("framing_error", {31'd0, framing_error}, {31'd0, e_fe});
      chk("overrun", {31'd0, overrun}, {31'd0, e_ov});
      if (data_out_valid === 1'b1) valid_cnt++;
      if (framing_error === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (data_out_valid === 1'b1 && prev_valid !== 1'b1) begin
        last_rise = cyc;
        last_rise_data = data_out;
      end
      prev_valid = data_out_valid;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      serial_in = 1'b1;
    end
  endtask

  // Drives one 8N1 frame, one line position per clock; f is the edge that samples position 0.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit vote_glitch,
                            input int abort_pos, input int ready_pos, output int f);
    int   j;
    int   off;
    int   gs;
    logic lvl;
    ev_t  ev;
    f = 0;
    for (int p = 0; p < FRAME_POS; p++) begin
      @(negedge clk);
      if (p == 0) begin
        f = cyc + 1;
        ev.cyc = f + DELIVER_OFS;
        ev.is_frame_err = !stop_bit;
        ev.data = b;
        evq.push_back(ev);
      end
      j = p / CYC_PER_BIT;
      off = p % CYC_PER_BIT;
      lvl = (j == 0) ? 1'b0 : (j == 9) ? stop_bit : b[j-1];
      gs = 10 * (7 + (j % 3)) + 10;
      if (vote_glitch && j >= 1 && j <= 8 && off >= gs - 2 && off <= gs + 2) lvl = ~lvl;
      if (p == ready_pos) data_out_ready = 1'b1;
      if (abort_pos >= 0 && p >= abort_pos) begin
        lvl = 1'b1;
        reset = (p < abort_pos + 3);
      end
      serial_in = lvl;
      if (abort_pos >= 0 && p >= abort_pos + 3) break;
    end
  endtask

  initial begin : main
    int f;
    int fe0;
    int ov0;
    int vc0;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data_out}, 32'h0);
    chk("reset_valid", {31'd0, data_out_valid}, 32'h0);
    chk("reset_flags", {30'd0, framing_error, overrun}, 32'h0);
    reset = 1'b0;
    idle(20);

    data_out_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, -1, -1, f);
    idle(50);
    chk("a5_latency", last_rise - (f + 1), 1541);
    chk("a5_data", {24'd0, last_rise_data}, 32'hA5);
    chk("a5_valid_cycles", valid_cnt - vc0, 1);
    chk("a5_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

    vc0 = valid_cnt; fe0 = fe_cnt;
    repeat (40) begin
      @(negedge clk);
      serial_in = 1'b0;
    end
    idle(400);
    chk("glitch_no_valid", valid_cnt - vc0, 0);
    chk("glitch_no_fe", fe_cnt - fe0, 0);
    send_frame(8'h5A, 1'b1, 1'b0, -1, -1, f);
    idle(50);
    chk("5a_data", {24'd0, last_rise_data}, 32'h5A);
    chk("5a_latency", last_rise - (f + 1), 1541);

    vc0 = valid_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1, f);
    idle(300);
    chk("3c_fe_once", fe_cnt - fe0, 1);
    chk("3c_no_valid", valid_cnt - vc0, 0);

    data_out_ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, 1'b0, -1, -1, f);
    idle(20);
    send_frame(8'h22, 1'b1, 1'b0, -1, -1, f);
    idle(60);
    chk("ovr_held_data", {24'd0, data_out}, 32'h11);
    chk("ovr_held_valid", {31'd0, data_out_valid}, 32'h1);
    chk("ovr_once", ov_cnt - ov0, 1);

    ov0 = ov_cnt;
    send_frame(8'h77, 1'b1, 1'b0, -1, DELIVER_OFS, f);
    idle(20);
    chk("same_cycle_no_ovr", ov_cnt - ov0, 0);
    chk("same_cycle_data", {24'd0, data_out}, 32'h77);
    chk("same_cycle_drained", {31'd0, data_out_valid}, 32'h0);

    send_frame(8'h96, 1'b1, 1'b1, -1, -1, f);
    idle(50);
    chk("vote_data", {24'd0, last_rise_data}, 32'h96);

    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cnt;
    send_frame(8'h69, 1'b1, 1'b0, 5 * CYC_PER_BIT + 50, -1, f);
    @(negedge clk);
    chk("abort_data", {24'd0, data_out}, 32'h0);
    chk("abort_valid", {31'd0, data_out_valid}, 32'h0);
    idle(200);
    chk("abort_no_flags", (fe_cnt - fe0) + (ov_cnt - ov0) + (valid_cnt - vc0), 0);
    send_frame(8'hC3, 1'b1, 1'b0, -1, -1, f);
    idle(50);
    chk("c3_data", {24'd0, last_rise_data}, 32'hC3);
    chk("c3_latency", last_rise - (f + 1), 1541);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
